mission_level_ctrl: RTL and testbench

- Parametrised successor to the fixed 5-subsystem, 3-level checker.
- One free-running XNOR LFSR generates a subsystem health vector (1 = working) each time a level is started.
- A multi-cycle repair engine fixes faulty critical subsystems within a per-level budget. The operator powers off non-critical subsystems; an FSM then evaluates pass/fail and advances through N_LEVELS levels.
- Sits between the switch/button front end and the status display.

---
 rtl/mission_level_ctrl.sv | 85 ++++++++
 tb/tb_mission_level_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mission_level_ctrl.sv
// mission_level_ctrl: LFSR-sampled subsystem health, bounded repair and per-level pass/fail sequencing; define AUTO_SHED_EN to auto-shed faulty non-critical subsystems
module mission_level_ctrl #(
  parameter int N_SUB = 5,
  parameter int N_LEVELS = 3,
  parameter logic [N_SUB-1:0] SEED = N_SUB'(5'b00001),
  parameter logic [N_SUB-1:0] TAPS = N_SUB'(5'b10100),
  parameter int REPAIR_MAX = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N_SUB-1:0]                sw_off,
  output logic [N_SUB-1:0]                sub_out,
  output logic [N_SUB-1:0]                crit_mask,
  output logic [$clog2(N_LEVELS+1)-1:0]   level,
  output logic                            busy,
  output logic                            level_passed,
  output logic                            level_failed,
  output logic                            game_won,
  output logic [$clog2(N_SUB+1)-1:0]      repairs_used,
  output logic [N_SUB-1:0]                lfsr_out
);
  localparam int LW = $clog2(N_LEVELS+1);
  localparam int RW = $clog2(N_SUB+1);
  localparam logic [RW-1:0] RMAX = RW'(REPAIR_MAX);
  localparam logic [LW-1:0] LMAX = LW'(N_LEVELS);
  typedef enum logic [2:0] {IDLE, REPAIR, EVAL, PASS, FAIL, DONE} state_t;
  state_t state, state_n;
  logic [N_SUB-1:0] sub_raw, sub_raw_n, need, fix;
  logic [RW-1:0] repairs_n;
  logic [LW-1:0] level_n;
  logic pass;
  assign crit_mask = {N_SUB{1'b1}} >> level;
  assign need = ~sub_raw & crit_mask;
  assign fix = need & (~need + N_SUB'(1));
`ifdef AUTO_SHED_EN
  assign pass = &(sub_raw | ~crit_mask);
`else
  assign pass = (&(sub_raw | ~crit_mask)) && (&(sub_raw | crit_mask | sw_off));
`endif
  assign busy = state == REPAIR || state == EVAL;
  assign level_passed = state == PASS;
  assign level_failed = state == FAIL;
  assign game_won = state == DONE;
  always_comb begin
    state_n = state;
    sub_raw_n = sub_raw;
    repairs_n = repairs_used;
    level_n = level;
    unique case (state)
      IDLE, FAIL: if (start) begin
        sub_raw_n = lfsr_out;
        repairs_n = '0;
        state_n = REPAIR;
      end
      REPAIR: if (|need && repairs_used < RMAX) begin
        sub_raw_n = sub_raw | fix;
        repairs_n = repairs_used + 1'b1;
      end else state_n = EVAL;
      EVAL: state_n = pass ? PASS : FAIL;
      PASS: begin
        state_n = level == LMAX ? DONE : IDLE;
        level_n = level == LMAX ? level : level + 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      lfsr_out <= SEED;
      level <= LW'(1);
      sub_raw <= '0;
      repairs_used <= '0;
      sub_out <= '0;
    end else begin
      state <= state_n;
      lfsr_out <= {lfsr_out[N_SUB-2:0], ~^(lfsr_out & TAPS)};
      level <= level_n;
      sub_raw <= sub_raw_n;
      repairs_used <= repairs_n;
      sub_out <= sub_raw & (crit_mask | ~sw_off);
    end
  end
endmodule

// File: tb/tb_mission_level_ctrl.sv
// tb_mission_level_ctrl: directed checks of mission_level_ctrl with REPAIR_MAX=2 (dut_a) and REPAIR_MAX=3 (dut_b)
module tb_mission_level_ctrl;
  logic clk = 1'b0;
  logic rst_a, rst_b, start_a, start_b;
  logic [4:0] sw_off;
  logic [4:0] sub_out_a, crit_a, lfsr_a, sub_out_b, crit_b, lfsr_b;
  logic [1:0] level_a, level_b;
  logic [2:0] rep_a, rep_b;
  logic busy_a, passed_a, failed_a, won_a, busy_b, passed_b, failed_b, won_b;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mission_level_ctrl dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .sw_off(sw_off), .sub_out(sub_out_a),
    .crit_mask(crit_a), .level(level_a), .busy(busy_a), .level_passed(passed_a),
    .level_failed(failed_a), .game_won(won_a), .repairs_used(rep_a), .lfsr_out(lfsr_a)
  );
  mission_level_ctrl #(.REPAIR_MAX(3)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .sw_off(sw_off), .sub_out(sub_out_b),
    .crit_mask(crit_b), .level(level_b), .busy(busy_b), .level_passed(passed_b),
    .level_failed(failed_b), .game_won(won_b), .repairs_used(rep_b), .lfsr_out(lfsr_b)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reset_both();
    rst_a = 1'b0;
    rst_b = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    tick(2);
  endtask
  initial begin
    sw_off = '0;
    reset_both();
    chk("rst_lfsr", lfsr_a, 5'b00001);
    chk("rst_level", level_a, 2'd1);
    chk("rst_crit", crit_a, 5'b01111);
    chk("rst_flags", {busy_a, passed_a, failed_a, won_a}, 4'b0000);
    chk("rst_sub_out", sub_out_a, 5'b00000);
    chk("rst_repairs", rep_a, 3'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    sw_off = 5'b10000;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    chk("lfsr_c1", lfsr_a, 5'b00011);
    chk("busy_a_c1", busy_a, 1'b1);
    chk("busy_b_c1", busy_b, 1'b1);
    chk("rep_a_c1", rep_a, 3'd0);
    tick();
    chk("lfsr_c2", lfsr_a, 5'b00111);
    chk("rep_a_c2", rep_a, 3'd1);
    tick();
    chk("lfsr_c3", lfsr_a, 5'b01110);
    chk("rep_a_c3", rep_a, 3'd2);
    chk("rep_b_c3", rep_b, 3'd2);
    tick();
    chk("busy_a_eval", busy_a, 1'b1);
    chk("rep_b_c4", rep_b, 3'd3);
    chk("failed_a_c4", failed_a, 1'b0);
    tick();
    chk("budget_failed", failed_a, 1'b1);
    chk("budget_rep", rep_a, 3'd2);
    chk("budget_level", level_a, 2'd1);
    chk("budget_busy", busy_a, 1'b0);
    chk("b_eval_busy", busy_b, 1'b1);
    chk("b_pass_early", passed_b, 1'b0);
    tick();
    chk("l1_passed", passed_b, 1'b1);
    chk("l1_sub_out", sub_out_b, 5'b01111);
    chk("l1_not_failed", failed_b, 1'b0);
    chk("fail_hold_a", failed_a, 1'b1);
    tick();
    chk("l2_level", level_b, 2'd2);
    chk("l2_crit", crit_b, 5'b00111);
    chk("l2_pulse_end", passed_b, 1'b0);
    chk("lfsr_c7", lfsr_b, 5'b00100);
    start_b = 1'b1;
    sw_off = 5'b11000;
    tick();
    start_b = 1'b0;
    chk("l2_busy", busy_b, 1'b1);
    chk("l2_rep0", rep_b, 3'd0);
    tick();
    chk("l2_rep1", rep_b, 3'd1);
    tick();
    chk("l2_rep2", rep_b, 3'd2);
    tick();
    chk("l2_eval", busy_b, 1'b1);
    tick();
    chk("l2_passed", passed_b, 1'b1);
    chk("l2_sub_out", sub_out_b, 5'b00111);
    tick();
    chk("l3_level", level_b, 2'd3);
    chk("l3_crit", crit_b, 5'b00011);
    chk("l3_idle", busy_b, 1'b0);
    tick(2);
    chk("lfsr_c15", lfsr_b, 5'b10111);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    sw_off = 5'b00000;
    chk("l3_busy", busy_b, 1'b1);
    chk("l3_rep0", rep_b, 3'd0);
    tick();
    sw_off = 5'b11000;
    chk("l3_eval", busy_b, 1'b1);
    chk("l3_no_early_pass", passed_b, 1'b0);
    tick();
    chk("l3_passed", passed_b, 1'b1);
    chk("l3_sub_out", sub_out_b, 5'b00111);
    chk("l3_level_hold", level_b, 2'd3);
    tick();
    chk("won", won_b, 1'b1);
    chk("won_level", level_b, 2'd3);
    chk("won_pulse_end", passed_b, 1'b0);
    start_b = 1'b1;
    tick(10);
    chk("won_ignore_start", won_b, 1'b1);
    chk("won_level_final", level_b, 2'd3);
    chk("won_not_busy", busy_b, 1'b0);
    reset_both();
    chk("b_rst_won", won_b, 1'b0);
    chk("b_rst_level", level_b, 2'd1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    sw_off = 5'b00000;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    tick();
    chk("mid_rep_a", rep_a, 3'd1);
    chk("mid_busy_a", busy_a, 1'b1);
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_level", level_a, 2'd1);
    chk("abort_lfsr", lfsr_a, 5'b00001);
    chk("abort_rep", rep_a, 3'd0);
    chk("abort_sub_out", sub_out_a, 5'b00000);
    tick(2);
    chk("abort_lfsr_step", lfsr_a, 5'b00111);
    chk("shed_eval", busy_b, 1'b1);
    chk("shed_no_early", passed_b, 1'b0);
    tick();
`ifdef AUTO_SHED_EN
    chk("shed_missing_pass", passed_b, 1'b1);
    chk("shed_missing_fail", failed_b, 1'b0);
`else
    chk("shed_missing_pass", passed_b, 1'b0);
    chk("shed_missing_fail", failed_b, 1'b1);
`endif
    chk("shed_level", level_b, 2'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
